// File: rtl/fleet_damage_tracker.sv
// Battleship fleet damage tracker: loads ship sizes, counts hits per ship, flags sinks and defeat.
// Optional HIT_EDGE_DETECT_EN: hit_in is treated as a level switch and only 0->1 edges count as hits.
module fleet_damage_tracker #(
   parameter int MAX_SHIPS = 5,
   parameter int MAX_SIZE  = 5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load_start,
   input  logic       i_load_ship,
   input  logic [2:0] i_load_size,
   input  logic       i_load_done,
   input  logic       i_hit_in,
   input  logic [2:0] i_hit_id,
   input  logic       i_new_game,
   output logic [1:0] o_state,
   output logic [2:0] o_ships_total,
   output logic [2:0] o_ships_remaining,
   output logic       o_sunk_pulse,
   output logic [2:0] o_sunk_id,
   output logic       o_reject_pulse,
   output logic       o_fleet_destroyed
);
   typedef enum logic [1:0] {IDLE = 2'd0, LOADING = 2'd1, ACTIVE = 2'd2, DEFEATED = 2'd3} state_t;

   state_t               r_state, w_next_state;
   logic [2:0]           r_size [MAX_SHIPS];
   logic [2:0]           r_hits [MAX_SHIPS];
   logic [MAX_SHIPS-1:0] r_sunk;
   logic [2:0]           r_total, r_remaining, r_sunk_id;
   logic                 r_sunk_pulse, r_reject, r_destroyed;

   logic       w_hit_evt, w_load_ok, w_hit_legal, w_sink;
   logic       w_store, w_clear, w_reject, w_hit, w_sink_en, w_new_game;
   logic [2:0] w_sel_size, w_sel_hits, w_total_upd;
   logic       w_sel_sunk;

`ifdef HIT_EDGE_DETECT_EN
   logic r_hit_prev;
   always_ff @(posedge i_clk) begin
      if (i_rst) r_hit_prev <= 1'b0;
      else       r_hit_prev <= i_hit_in;
   end
   assign w_hit_evt = i_hit_in && !r_hit_prev;
`else
   assign w_hit_evt = i_hit_in;
`endif

   always_comb begin
      w_sel_size = '0;
      w_sel_hits = '0;
      w_sel_sunk = 1'b0;
      for (int i = 0; i < MAX_SHIPS; i++) begin
         if (i_hit_id == 3'(i)) begin
            w_sel_size = r_size[i];
            w_sel_hits = r_hits[i];
            w_sel_sunk = r_sunk[i];
         end
      end
   end

   assign w_load_ok   = i_load_ship && (i_load_size != 3'd0) && (i_load_size <= 3'(MAX_SIZE))
                        && (r_total < 3'(MAX_SHIPS));
   assign w_total_upd = r_total + {2'b00, w_load_ok};
   // A ship below its size can take one more hit without overflowing the counter
   assign w_hit_legal = (i_hit_id < r_total) && !w_sel_sunk;
   assign w_sink      = (w_sel_hits + 3'd1) == w_sel_size;
   assign w_new_game  = (r_state == DEFEATED) && i_new_game;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_store      = 1'b0;
      w_clear      = 1'b0;
      w_reject     = 1'b0;
      w_hit        = 1'b0;
      w_sink_en    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_load_start) begin
               w_next_state = LOADING;
               w_clear      = 1'b1;
            end
         end
         LOADING: begin
            w_store = w_load_ok;
            if (i_load_ship && !w_load_ok) w_reject = 1'b1;
            if (i_load_done) begin
               if (w_total_upd != 3'd0) w_next_state = ACTIVE;
               else                     w_reject     = 1'b1;
            end
         end
         ACTIVE: begin
            if (w_hit_evt) begin
               if (w_hit_legal) begin
                  w_hit = 1'b1;
                  if (w_sink) begin
                     w_sink_en = 1'b1;
                     if (r_remaining == 3'd1) w_next_state = DEFEATED;
                  end
               end else begin
                  w_reject = 1'b1;
               end
            end
         end
         DEFEATED: begin
            if (i_new_game) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < MAX_SHIPS; i++) begin
            r_size[i] <= '0;
            r_hits[i] <= '0;
         end
         r_sunk       <= '0;
         r_total      <= '0;
         r_remaining  <= '0;
         r_sunk_id    <= '0;
         r_sunk_pulse <= 1'b0;
         r_reject     <= 1'b0;
         r_destroyed  <= 1'b0;
      end else begin
         r_sunk_pulse <= w_sink_en;
         r_reject     <= w_reject;
         r_destroyed  <= (w_next_state == DEFEATED);
         if (w_clear) begin
            for (int i = 0; i < MAX_SHIPS; i++) begin
               r_size[i] <= '0;
               r_hits[i] <= '0;
            end
            r_sunk      <= '0;
            r_total     <= '0;
            r_remaining <= '0;
         end
         if (w_store) begin
            for (int i = 0; i < MAX_SHIPS; i++)
               if (r_total == 3'(i)) r_size[i] <= i_load_size;
            r_total     <= w_total_upd;
            r_remaining <= r_remaining + 3'd1;
         end
         if (w_hit) begin
            for (int i = 0; i < MAX_SHIPS; i++) begin
               if (i_hit_id == 3'(i)) begin
                  r_hits[i] <= r_hits[i] + 3'd1;
                  if (w_sink) r_sunk[i] <= 1'b1;
               end
            end
            if (w_sink) begin
               r_sunk_id   <= i_hit_id;
               r_remaining <= r_remaining - 3'd1;
            end
         end
         if (w_new_game) begin
            r_total     <= '0;
            r_remaining <= '0;
         end
      end
   end

   assign o_state           = r_state;
   assign o_ships_total     = r_total;
   assign o_ships_remaining = r_remaining;
   assign o_sunk_pulse      = r_sunk_pulse;
   assign o_sunk_id         = r_sunk_id;
   assign o_reject_pulse    = r_reject;
   assign o_fleet_destroyed = r_destroyed;
endmodule

// File: tb/tb_fleet_damage_tracker.sv
// Self-checking bench for fleet_damage_tracker: directed game scenarios plus random stimulus
// compared every cycle against a behavioural game model.
module tb_fleet_damage_tracker;
   localparam int MAX_SHIPS = 5;
   localparam int MAX_SIZE  = 5;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0, i_load_start = 1'b0, i_load_ship = 1'b0, i_load_done = 1'b0;
   logic       i_hit_in = 1'b0, i_new_game = 1'b0;
   logic [2:0] i_load_size = 3'd0, i_hit_id = 3'd0;
   logic [1:0] o_state;
   logic [2:0] o_ships_total, o_ships_remaining, o_sunk_id;
   logic       o_sunk_pulse, o_reject_pulse, o_fleet_destroyed;

   fleet_damage_tracker #(.MAX_SHIPS(MAX_SHIPS), .MAX_SIZE(MAX_SIZE)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_load_start(i_load_start), .i_load_ship(i_load_ship),
      .i_load_size(i_load_size), .i_load_done(i_load_done), .i_hit_in(i_hit_in),
      .i_hit_id(i_hit_id), .i_new_game(i_new_game), .o_state(o_state),
      .o_ships_total(o_ships_total), .o_ships_remaining(o_ships_remaining),
      .o_sunk_pulse(o_sunk_pulse), .o_sunk_id(o_sunk_id), .o_reject_pulse(o_reject_pulse),
      .o_fleet_destroyed(o_fleet_destroyed)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // game model: fleet as arrays of sizes and damage, a ship is sunk when damage equals size
   int m_state = 0, m_total = 0, m_rem = 0, m_sid = 0;
   bit m_sp = 0, m_rj = 0, m_dest = 0, m_prev = 0;
   int m_sz [8];
   int m_dmg [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      bit evt;
      int id;
      m_sp = 0;
      m_rj = 0;
      if (i_rst) begin
         m_state = 0; m_total = 0; m_rem = 0; m_sid = 0; m_dest = 0; m_prev = 0;
         for (int i = 0; i < 8; i++) begin m_sz[i] = 0; m_dmg[i] = 0; end
         return;
      end
`ifdef HIT_EDGE_DETECT_EN
      evt = i_hit_in && !m_prev;
`else
      evt = i_hit_in;
`endif
      m_prev = i_hit_in;
      id = int'(i_hit_id);
      case (m_state)
         0: if (i_load_start) begin
               m_state = 1; m_total = 0; m_rem = 0;
               for (int i = 0; i < 8; i++) begin m_sz[i] = 0; m_dmg[i] = 0; end
            end
         1: begin
               if (i_load_ship) begin
                  if (i_load_size >= 1 && i_load_size <= MAX_SIZE && m_total < MAX_SHIPS) begin
                     m_sz[m_total] = int'(i_load_size); m_dmg[m_total] = 0;
                     m_total++; m_rem++;
                  end else m_rj = 1;
               end
               if (i_load_done) begin
                  if (m_total > 0) m_state = 2;
                  else m_rj = 1;
               end
            end
         2: if (evt) begin
               if (id < m_total && m_dmg[id] < m_sz[id]) begin
                  m_dmg[id]++;
                  if (m_dmg[id] == m_sz[id]) begin
                     m_sp = 1; m_sid = id; m_rem--;
                     if (m_rem == 0) begin m_state = 3; m_dest = 1; end
                  end
               end else m_rj = 1;
            end
         default: if (i_new_game) begin
               m_state = 0; m_total = 0; m_rem = 0; m_dest = 0;
            end
      endcase
   endtask

   // one clock: inputs already applied, model advances on the edge, outputs compared 1ns later
   task automatic step();
      @(posedge i_clk);
      model_step();
      #1;
      chk("state", o_state, m_state);
      chk("total", o_ships_total, m_total);
      chk("remaining", o_ships_remaining, m_rem);
      chk("sunk_pulse", o_sunk_pulse, m_sp);
      chk("sunk_id", o_sunk_id, m_sid);
      chk("reject", o_reject_pulse, m_rj);
      chk("destroyed", o_fleet_destroyed, m_dest);
      i_rst = 0; i_load_start = 0; i_load_ship = 0; i_load_done = 0; i_new_game = 0;
   endtask

   task automatic do_reset();
      i_rst = 1; i_hit_in = 0; step();
   endtask

   task automatic load_ship(input int sz);
      i_load_ship = 1; i_load_size = 3'(sz); step();
   endtask

   task automatic hit(input int id, output bit rj, output bit sp);
      i_hit_id = 3'(id); i_hit_in = 1; step();
      rj = o_reject_pulse; sp = o_sunk_pulse;
      i_hit_in = 0; step();
   endtask

   initial begin
      bit rj, sp;
      int nsp;
      // reset values
      i_rst = 1; step();
      chk("rst_state", o_state, 0);
      chk("rst_total", o_ships_total, 0);

      // load and arm
      i_load_start = 1; step();
      load_ship(2); load_ship(3);
      i_load_done = 1; step();
      chk("arm_total", o_ships_total, 2);
      chk("arm_rem", o_ships_remaining, 2);
      chk("arm_state", o_state, 2);

      // sink ship 0
      nsp = 0;
      hit(0, rj, sp); nsp += int'(sp);
      hit(0, rj, sp); nsp += int'(sp);
      chk("sink0_pulses", nsp, 1);
      chk("sink0_id", o_sunk_id, 0);
      chk("sink0_rem", o_ships_remaining, 1);
      hit(0, rj, sp);
      chk("rehit_reject", rj, 1);

      // defeat
      hit(1, rj, sp); hit(1, rj, sp); hit(1, rj, sp);
      chk("def_sp", sp, 1);
      chk("def_state", o_state, 3);
      chk("def_flag", o_fleet_destroyed, 1);
      chk("def_rem", o_ships_remaining, 0);
      hit(1, rj, sp);
      chk("def_nohit_rej", rj, 0);
      i_new_game = 1; step();
      chk("ng_state", o_state, 0);
      chk("ng_sunk_id_held", o_sunk_id, 1);

      // illegal loads
      i_load_start = 1; step();
      i_load_done = 1; step();
      chk("empty_done_rej", o_reject_pulse, 1);
      chk("empty_done_state", o_state, 1);
      load_ship(0); chk("size0_rej", o_reject_pulse, 1);
      load_ship(6); chk("size6_rej", o_reject_pulse, 1);
      for (int i = 0; i < 5; i++) load_ship(1);
      load_ship(1); chk("sixth_rej", o_reject_pulse, 1);
      chk("full_total", o_ships_total, 5);

      // edge detect: hold hit_in 4 cycles on a single size-3 ship
      do_reset();
      i_load_start = 1; step();
      load_ship(3);
      i_load_ship = 1; i_load_size = 3'd3; i_load_done = 1; step();
      chk("same_cycle_total", o_ships_total, 2);
      chk("same_cycle_state", o_state, 2);
      i_hit_id = 3'd0; i_hit_in = 1;
      for (int i = 0; i < 4; i++) step();
      i_hit_in = 0; step();
`ifdef HIT_EDGE_DETECT_EN
      chk("held_rem", o_ships_remaining, 2);
`else
      chk("held_rem", o_ships_remaining, 1);
`endif

      // mid-game reset with one ship sunk
      do_reset();
      i_load_start = 1; step();
      load_ship(2); load_ship(3);
      i_load_done = 1; step();
      hit(0, rj, sp); hit(0, rj, sp);
      i_rst = 1; step();
      chk("mid_rst_state", o_state, 0);
      chk("mid_rst_total", o_ships_total, 0);
      chk("mid_rst_sid", o_sunk_id, 0);
      i_load_start = 1; step();
      load_ship(1);
      i_load_done = 1; step();
      hit(0, rj, sp);
      chk("fresh_sp", sp, 1);
      chk("fresh_state", o_state, 3);

      // random play against the model
      for (int c = 0; c < 4000; c++) begin
         i_rst        = ($urandom_range(0, 299) == 0);
         i_new_game   = ($urandom_range(0, 19) == 0);
         i_load_start = ($urandom_range(0, 9) == 0);
         i_load_ship  = ($urandom_range(0, 2) == 0);
         i_load_size  = 3'($urandom_range(0, 7));
         i_load_done  = ($urandom_range(0, 7) == 0);
         i_hit_in     = ($urandom_range(0, 1) == 0);
         i_hit_id     = 3'($urandom_range(0, 6));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fleet_damage_tracker.md
# fleet_damage_tracker

Tracks damage on a placed fleet during the firing phase of the Battleship game. The placement side loads each ship's size once. The tracker then takes hits addressed to a ship index, counts hits per ship, and flags each ship as it sinks. It reports remaining ships and raises a defeat flag when the whole fleet is gone. It sits after the ship-placement logic and feeds the game controller's win/lose decision.

## Interface
- MAX_SHIPS, 5: fleet capacity, 1..7.
- MAX_SIZE, 5: largest legal ship size, 1..7.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- load_start  in  1  strobe: IDLE -> LOADING.
- load_ship  in  1  strobe: append one ship of size load_size.
- load_size  in  3  size of ship being loaded.
- load_done  in  1  strobe: placement finished.
- hit_in  in  1  fire input; see Configuration.
- hit_id  in  3  index of ship hit.
- new_game  in  1  strobe: DEFEATED -> IDLE.
- state  out  2  IDLE=0, LOADING=1, ACTIVE=2, DEFEATED=3.
- ships_total  out  3  ships loaded.
- ships_remaining  out  3  unsunk ships.
- sunk_pulse  out  1  one-cycle pulse when a ship sinks.
- sunk_id  out  3  index of last sunk ship; holds between pulses.
- reject_pulse  out  1  one-cycle pulse on any illegal load or hit.
- fleet_destroyed  out  1  high while in DEFEATED.

## Operation
- All outputs are registered. On rst they are: state=IDLE, ships_total=0, ships_remaining=0, sunk_pulse=0, sunk_id=0, reject_pulse=0, fleet_destroyed=0.
- rst also clears all per-ship size, hit-count and sunk registers.
- **IDLE**
  - load_start -> LOADING, which clears the fleet registers.
  - All other inputs are ignored; no reject is raised.
- **LOADING**
  - load_ship with 1 <= load_size <= MAX_SIZE and ships_total < MAX_SHIPS:
    - stores the size at index ships_total;
    - increments ships_total and ships_remaining.
  - Any other load_ship is ignored and raises reject_pulse.
  - load_done with ships_total > 0 -> ACTIVE.
  - load_done with ships_total = 0 stays in LOADING and raises reject_pulse.
  - load_ship and load_done in the same cycle: the ship is stored first. The transition test uses the updated count.
- **ACTIVE**
  - A hit event is legal only when hit_id < ships_total and the ship is not sunk.
  - A legal hit increments that ship's hit counter (3-bit, saturates at its size).
  - When the counter reaches the size:
    - the ship is marked sunk;
    - sunk_pulse is raised and sunk_id takes hit_id;
    - ships_remaining is decremented.
  - When ships_remaining goes 1 -> 0: -> DEFEATED, fleet_destroyed goes high.
  - An illegal hit (out-of-range id, or ship already sunk) raises reject_pulse and changes nothing else.
  - Load inputs are ignored in ACTIVE.
- **DEFEATED**
  - Holds all counts.
  - new_game -> IDLE: clears ships_total, ships_remaining and fleet_destroyed; sunk_id is held.
  - Hits are ignored.
- Precedence: rst > new_game > load_done > load_ship/hit.

## Timing
- Outputs reflect an input strobe one cycle after the sampling edge. Latency is 1 clk.
- sunk_pulse, the ships_remaining decrement, and the DEFEATED transition all appear in the same cycle.
- At most one hit is processed per cycle.
- Asserting rst in any state returns to IDLE at the next edge. An in-flight pulse is dropped.

## Configuration
- HIT_EDGE_DETECT_EN
  - **Defined:** hit_in is a level switch.
    - A hit event is a 0->1 transition, detected with a registered previous value (reset to 0).
    - Holding hit_in high counts once.
  - **Undefined:** every cycle with hit_in=1 in ACTIVE is a hit event.

## Test plan
- **Load and arm:** load_start; load sizes 2,3; load_done. -> ships_total=2, ships_remaining=2, state=ACTIVE.
- **Sink one ship:** fleet {2,3}; two hits on id 0. -> sunk_pulse once with sunk_id=0, ships_remaining=1. A third hit on id 0 -> reject_pulse.
- **Defeat:** continue with three hits on id 1. -> state=DEFEATED, fleet_destroyed=1, ships_remaining=0. A further hit -> no reject_pulse.
- **Illegal loads:**
  - load_size=0 -> reject_pulse.
  - load_size=6 -> reject_pulse.
  - A sixth ship with MAX_SHIPS=5 -> reject_pulse.
  - load_done with 0 ships -> reject_pulse, state stays LOADING.
- **Edge detect:** with HIT_EDGE_DETECT_EN, hit_in held high 4 cycles on a size-3 ship -> 1 hit counted. Without the macro -> ship sinks on cycle 3.
- **Mid-game reset:** rst in ACTIVE with 1 ship sunk -> all outputs at reset values next cycle. Reload and a fresh game proceed correctly.
